// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: mode controller for the digital clock.
// Steps between run mode and NUM_FIELDS settable fields, generates increment
// strobes with auto-repeat, and falls back to run mode after an idle timeout.
// Optional feature: define CLOCK_MODE_BLINK_EN to enable the field blink output;
// with it undefined, blink is tied low and no blink counter exists.
module clock_mode_ctrl #(
    parameter int NUM_FIELDS     = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100,
    parameter int CNT_W          = 16,
    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  set,
    input  logic                  inc,
    output logic [NUM_FIELDS-1:0] field_sel,
    output logic [IDX_W-1:0]      field_idx,
    output logic                  clk_select,
    output logic                  inc_pulse,
    output logic                  timeout_pulse,
    output logic                  blink
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } mode_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_DELAY    = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PERIOD   = CNT_W'(REPEAT_PERIOD);
    localparam logic [IDX_W-1:0] LAST_FIELD   = IDX_W'(NUM_FIELDS - 1);

`ifdef CLOCK_MODE_BLINK_EN
    localparam int               BLINK_HALF = (TIMEOUT_CYCLES / 8 < 1) ? 1 : TIMEOUT_CYCLES / 8;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
    logic [CNT_W-1:0] blink_cnt;
`endif

    mode_t            state;
    logic             set_q;
    logic             inc_q;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             set_rise;
    logic             inc_rise;

    function automatic logic [NUM_FIELDS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = NUM_FIELDS'(1) << idx;
    endfunction

    // Button edges are taken against the previous-cycle sample of each level.
    always_comb begin
        set_rise = set & ~set_q;
        inc_rise = inc & ~inc_q;
    end

    // Mode FSM: field stepping, increment/auto-repeat strobes and idle timeout.
    // rep_cnt == 0 means no repeat sequence is armed; a field change disarms it
    // so a held inc button only repeats after a fresh press.
    always_ff @(posedge clk) begin
        set_q <= set;
        inc_q <= inc;
        if (reset) begin
            state         <= ST_RUN;
            field_idx     <= '0;
            field_sel     <= '0;
            clk_select    <= 1'b0;
            inc_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
            to_cnt        <= '0;
            rep_cnt       <= '0;
`ifdef CLOCK_MODE_BLINK_EN
            blink         <= 1'b0;
            blink_cnt     <= '0;
`endif
        end else begin
            inc_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (set_rise && !start) begin
                        state      <= ST_SET;
                        field_idx  <= '0;
                        field_sel  <= onehot('0);
                        clk_select <= 1'b1;
                        to_cnt     <= '0;
                        rep_cnt    <= '0;
`ifdef CLOCK_MODE_BLINK_EN
                        blink      <= 1'b1;
                        blink_cnt  <= '0;
`endif
                    end
                end
                ST_SET: begin
`ifdef CLOCK_MODE_BLINK_EN
                    if (inc_pulse) begin
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                    end else if (blink_cnt >= BLINK_LAST) begin
                        blink     <= ~blink;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
`endif
                    if (start) begin
                        state      <= ST_RUN;
                        field_idx  <= '0;
                        field_sel  <= '0;
                        clk_select <= 1'b0;
`ifdef CLOCK_MODE_BLINK_EN
                        blink      <= 1'b0;
`endif
                    end else if (set_rise) begin
                        field_idx <= (field_idx == LAST_FIELD) ? '0 : field_idx + 1'b1;
                        field_sel <= onehot((field_idx == LAST_FIELD) ? '0 : field_idx + 1'b1);
                        to_cnt    <= '0;
                        rep_cnt   <= '0;
                    end else if (inc_rise) begin
                        inc_pulse <= 1'b1;
                        to_cnt    <= '0;
                        rep_cnt   <= REP_DELAY;
                    end else if (inc && rep_cnt == CNT_W'(1)) begin
                        inc_pulse <= 1'b1;
                        to_cnt    <= '0;
                        rep_cnt   <= REP_PERIOD;
                    end else begin
                        if (!inc) begin
                            rep_cnt <= '0;
                        end else if (rep_cnt != '0) begin
                            rep_cnt <= rep_cnt - 1'b1;
                        end
                        if (to_cnt >= TIMEOUT_LAST) begin
                            state         <= ST_RUN;
                            field_idx     <= '0;
                            field_sel     <= '0;
                            clk_select    <= 1'b0;
                            timeout_pulse <= 1'b1;
`ifdef CLOCK_MODE_BLINK_EN
                            blink         <= 1'b0;
`endif
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifndef CLOCK_MODE_BLINK_EN
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: self-checking bench for clock_mode_ctrl with a
// cycle-level behavioural model, directed scenarios and random stimulus.
module tb_clock_mode_ctrl;

    localparam int N  = 3;
    localparam int T  = 16;
    localparam int D  = 8;
    localparam int P  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       set = 1'b0;
    logic       inc = 1'b0;
    logic [2:0] field_sel;
    logic [1:0] field_idx;
    logic       clk_select;
    logic       inc_pulse;
    logic       timeout_pulse;
    logic       blink;

    int  checks = 0;
    int  errors = 0;
    bit  check_en = 0;

    // model state
    int  m_cyc = 0;
    int  m_last_act = 0;
    int  m_rise_at = 0;
    int  m_idx = 0;
    bit  m_in_set = 0;
    bit  m_rep_on = 0;
    bit  m_prev_set = 0;
    bit  m_prev_inc = 0;
    bit  m_exp_inc = 0;
    bit  m_exp_to = 0;

    clock_mode_ctrl #(
        .NUM_FIELDS(N), .TIMEOUT_CYCLES(T), .REPEAT_DELAY(D),
        .REPEAT_PERIOD(P), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .set(set), .inc(inc),
        .field_sel(field_sel), .field_idx(field_idx), .clk_select(clk_select),
        .inc_pulse(inc_pulse), .timeout_pulse(timeout_pulse), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic st, input logic s,
                                 input logic i, input int n);
        reset = r;
        start = st;
        set   = s;
        inc   = i;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: tracks mode, field, time of last activity and the
    // time of the accepted inc press; pulses follow from elapsed cycle counts.
    always @(posedge clk) begin
        bit sr;
        bit ir;
        int held;
        sr = set && !m_prev_set;
        ir = inc && !m_prev_inc;
        m_prev_set = set;
        m_prev_inc = inc;
        m_exp_inc = 0;
        m_exp_to  = 0;
        if (reset) begin
            m_in_set = 0;
            m_idx    = 0;
            m_rep_on = 0;
        end else if (!m_in_set) begin
            if (sr && !start) begin
                m_in_set   = 1;
                m_idx      = 0;
                m_last_act = m_cyc;
                m_rep_on   = 0;
            end
        end else begin
            if (start) begin
                m_in_set = 0;
            end else if (sr) begin
                m_idx      = (m_idx + 1) % N;
                m_last_act = m_cyc;
                m_rep_on   = 0;
            end else if (ir) begin
                m_exp_inc  = 1;
                m_last_act = m_cyc;
                m_rep_on   = 1;
                m_rise_at  = m_cyc;
            end else begin
                if (!inc) m_rep_on = 0;
                held = m_cyc - m_rise_at;
                if (m_rep_on && held >= D && ((held - D) % P) == 0) begin
                    m_exp_inc  = 1;
                    m_last_act = m_cyc;
                end else if (m_cyc - m_last_act >= T) begin
                    m_in_set = 0;
                    m_exp_to = 1;
                end
            end
        end
        m_cyc++;
    end

    // Every cycle compare all DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("field_sel", field_sel, m_in_set ? (1 << m_idx) : 0);
            checkOutput("field_idx", field_idx, m_in_set ? m_idx : 0);
            checkOutput("clk_select", clk_select, m_in_set);
            checkOutput("inc_pulse", inc_pulse, m_exp_inc);
            checkOutput("timeout_pulse", timeout_pulse, m_exp_to);
`ifdef CLOCK_MODE_BLINK_EN
            if (!m_in_set) checkOutput("blink_run", blink, 0);
`else
            checkOutput("blink", blink, 0);
`endif
        end
    end

    initial begin
        int exp_idx[4] = '{0, 1, 2, 0};
        int exp_sel[4] = '{1, 2, 4, 1};
        int exp_rep[7] = '{1, 9, 13, 17, 21, 25, 29};
        int pulses[$];
        int cnt;
        int tos;
        int k;
        logic r_start, r_set, r_inc, r_reset;

        // reset with set held: no edge afterwards
        applyStimulus(1, 0, 1, 0, 1);
        check_en = 1;
        applyStimulus(1, 0, 1, 0, 2);
        applyStimulus(0, 0, 1, 0, 3);
        checkOutput("held_set_sel", field_sel, 0);
        checkOutput("held_set_clksel", clk_select, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("set_fall_clksel", clk_select, 0);

        // four set presses step the field
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 1);
            checkOutput("step_idx", field_idx, exp_idx[i]);
            checkOutput("step_sel", field_sel, exp_sel[i]);
            checkOutput("step_clksel", clk_select, 1);
            applyStimulus(0, 0, 0, 0, 1);
        end

        // move to field 1 and press inc for two cycles
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("single_inc_first", inc_pulse, 1);
        cnt = inc_pulse;
        applyStimulus(0, 0, 0, 1, 1);
        cnt += inc_pulse;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            cnt += inc_pulse;
        end
        checkOutput("single_inc_count", cnt, 1);
        checkOutput("single_inc_idx", field_idx, 1);

        // hold inc for 30 cycles: auto-repeat schedule
        tos = 0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(0, 0, 0, 1, 1);
            if (inc_pulse) pulses.push_back(i);
            tos += timeout_pulse;
        end
        checkOutput("repeat_count", pulses.size(), 7);
        for (int i = 0; i < 7 && i < pulses.size(); i++)
            checkOutput("repeat_cycle", pulses[i], exp_rep[i]);
        checkOutput("repeat_no_timeout", tos, 0);
        checkOutput("repeat_clksel", clk_select, 1);

        // start aborts setting, then idle timeout
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("start_exit", clk_select, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("enter_again", clk_select, 1);
        k = 0;
        while (k < 40) begin
            applyStimulus(0, 0, 0, 0, 1);
            k++;
            if (clk_select == 1'b0) break;
        end
        checkOutput("timeout_cycles", k, 16);
        checkOutput("timeout_pulse_hi", timeout_pulse, 1);
        checkOutput("timeout_sel", field_sel, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("timeout_pulse_lo", timeout_pulse, 0);

        // set press on the expiry cycle wins over the timeout
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 15);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("expiry_set_idx", field_idx, 1);
        checkOutput("expiry_set_clksel", clk_select, 1);
        checkOutput("expiry_set_to", timeout_pulse, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // start together with an inc edge
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("start_inc_clksel", clk_select, 0);
        checkOutput("start_inc_pulse", inc_pulse, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // reset asserted mid-SET
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("midreset_sel", field_sel, 0);
        checkOutput("midreset_idx", field_idx, 0);
        checkOutput("midreset_clksel", clk_select, 0);
        checkOutput("midreset_inc", inc_pulse, 0);
        checkOutput("midreset_to", timeout_pulse, 0);
        applyStimulus(0, 0, 0, 0, 2);

        // random traffic, alternating busy and sparse set activity
        r_set = 0;
        r_inc = 0;
        for (int c = 0; c < 4000; c++) begin
            r_start = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, ((c / 500) % 2) ? 40 : 6) == 0) r_set = ~r_set;
            if ($urandom_range(0, 15) == 0) r_inc = ~r_inc;
            r_reset = ($urandom_range(0, 999) == 0);
            applyStimulus(r_reset, r_start, r_set, r_inc, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
